micro_core: RTL
===============

# micro_core

Parametrised accumulator microprocessor core and the next generation of the 8-bit micro top level. It merges fetch/decode/execute control, ALU and reset synchroniser into one block. It generalises data, address and operand widths, and replaces fixed single-cycle ROM/RAM access with a req/ack wait-state handshake. Optionally, a bus watchdog traps stalled accesses.

## Interface
- DATA_WIDTH, 8: accumulator, ALU and RAM data width.
- ROM_ADDR_WIDTH, 10: program counter / ROM address width.
- RAM_ADDR_WIDTH, 8: RAM address width.
- OPW, 10: instruction operand width.
  - Must be ≥ DATA_WIDTH, RAM_ADDR_WIDTH and ROM_ADDR_WIDTH.
  - Low bits are used as the immediate or address.
- WAIT_LIMIT, 15: watchdog limit in cycles; only used with MICRO_WDT_EN.
- clk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- rom_req  out  1  instruction fetch request.
- rom_addr  out  ROM_ADDR_WIDTH  fetch address (PC).
- rom_ack  in  1  fetch complete; rom_data is valid in the same cycle.
- rom_data  in  4+OPW  instruction {opcode[3:0], operand[OPW-1:0]}.
- ram_req  out  1  data access request.
- ram_we  out  1  1 = write, 0 = read; valid while ram_req is high.
- ram_addr  out  RAM_ADDR_WIDTH  data address.
- ram_wdata  out  DATA_WIDTH  write data (AR).
- ram_ack  in  1  access complete; ram_rdata is valid in the same cycle.
- ram_rdata  in  DATA_WIDTH  read data.
- acc  out  DATA_WIDTH  accumulator AR.
- flags  out  4  {V,N,C,Z}.
- halted  out  1  core is in HALT.
- error  out  1  core is in ERROR.

## Operation
- Reset synchroniser:
  - Two flops are set asynchronously by arst and cleared by clk.
  - Internal reset = arst OR the second flop.
  - Every output is 0 while internal reset is high.
- State machine: FETCH, DECODE, READ, WRITE, EXEC, HALT, ERROR. Reset state is FETCH with PC = 0.
- FETCH:
  - rom_req = 1 and rom_addr = PC.
  - On rom_ack: IR <= rom_data, PC <= PC+1 (wraps modulo 2^ROM_ADDR_WIDTH), go to DECODE.
- DECODE (1 cycle):
  - Opcodes 2, 4–8 go to READ; opcode 3 goes to WRITE.
  - Opcodes 0, 1, 9–C go to EXEC; D goes to HALT.
  - E and F go to ERROR.
- READ:
  - ram_req = 1, ram_we = 0, ram_addr = operand[RAM_ADDR_WIDTH-1:0].
  - On ram_ack: MBR <= ram_rdata, go to EXEC.
- WRITE:
  - ram_req = 1, ram_we = 1, ram_wdata = AR.
  - On ram_ack: go to FETCH. Flags are unchanged.
- EXEC (1 cycle), then FETCH. Opcodes:
  - 0 NOP.
  - 1 LDI: AR = imm.
  - 2 LD: AR = MBR.
  - 4 ADD: AR = AR+MBR.
  - 5 SUB: AR = AR−MBR.
  - 6 AND, 7 OR, 8 XOR: AR = AR op MBR.
  - 9 ADDI: AR = AR+imm.
  - A JMP: PC = target.
  - B JZ: PC = target if Z.
  - C JC: PC = target if C.
- Immediate = operand[DATA_WIDTH-1:0]; jump target = operand[ROM_ADDR_WIDTH-1:0].
- Flags:
  - ADD/ADDI: C = carry out of the DATA_WIDTH-bit add; V = signed overflow; Z, N from the result.
  - SUB: C = borrow (AR < MBR unsigned); V = signed overflow; Z, N from the result.
  - AND/OR/XOR: Z, N updated; V = 0; C held.
  - LD/LDI: Z, N updated; C, V held.
  - NOP, jumps and ST: no flag change.
- HALT and ERROR are absorbing: all requests are 0, and only reset exits.
- Request rules:
  - Once asserted, a req stays high with stable addr/we/wdata until its ack.
  - ack outside a req is ignored.
  - Only one of rom_req and ram_req is ever high.

## Timing
- First fetch: rom_req rises on the second clk edge after arst falls.
- Zero-wait latency (ack in the same cycle as req), counted FETCH to next FETCH:
  - LDI, ADDI, NOP and jumps: 3 cycles.
  - ST: 3 cycles.
  - LD and RAM ALU ops: 4 cycles.
- Each wait cycle (req high, ack low) adds exactly one cycle.
- acc and flags update on the clk edge that leaves EXEC.
- PC updates on the fetch ack edge and on a taken jump in EXEC.
- arst mid-access: requests drop to 0 immediately (asynchronously). Nothing is written to AR, PC or flags.

## Configuration
- MICRO_WDT_EN defined:
  - A counter clears on entry to FETCH, READ or WRITE and increments each cycle while req is high and ack is low.
  - If the count reaches WAIT_LIMIT, the core goes to ERROR on the next edge.
- MICRO_WDT_EN undefined: there is no counter, and the core waits for ack indefinitely.

## Test plan
- Reset, then zero-wait ROM with LDI 0x7F; ADDI 0x01:
  - acc = 0x80, flags V=1 N=1 C=0 Z=0.
  - The 2nd rom_req rises 3 cycles after the 1st.
- RAM[5] = 0x10; program LDI 0x10; SUB 5; JZ 0x20:
  - Z=1, C=0.
  - Next rom_addr = 0x020.
- ST 0x33 with AR = 0xA5 and ram_ack delayed 4 cycles:
  - ram_req/ram_we/ram_addr = 0x33 / ram_wdata = 0xA5 are held stable for 5 cycles.
  - One write is performed; the next fetch follows.
- Opcode 0xE fetched:
  - error = 1 on the cycle after DECODE; no further req.
  - HALT (0xD) sets halted = 1 in the same way.
- With MICRO_WDT_EN and WAIT_LIMIT = 15, ram_ack held low on LD: error = 1 after 16 cycles of ram_req.
- arst asserted while rom_req is high and waiting:
  - All outputs go to 0 immediately.
  - After release, the fetch restarts at rom_addr = 0.

Source files
------------

// File: rtl/micro_core_if.sv
// micro_core_if: ROM fetch and RAM data req/ack buses of micro_core.
// master = core side, slave = memory side.
interface micro_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROM_ADDR_WIDTH = 10,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int OPW = 10
);
    logic rom_req;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr;
    logic rom_ack;
    logic [OPW+3:0] rom_data;
    logic ram_req;
    logic ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic ram_ack;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output rom_req, rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
        input  rom_ack, rom_data, ram_ack, ram_rdata
    );

    modport slave (
        input  rom_req, rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
        output rom_ack, rom_data, ram_ack, ram_rdata
    );
endinterface

// File: rtl/micro_core.sv
// micro_core: parametrised accumulator core with req/ack ROM and RAM buses.
// Define MICRO_WDT_EN to trap accesses stalled for WAIT_LIMIT cycles into ERROR.
module micro_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ROM_ADDR_WIDTH = 10,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int OPW = 10,
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic arst,
    micro_core_if.master bus,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [3:0] flags,
    output logic halted,
    output logic error
);
    localparam int DW = DATA_WIDTH;

    if (OPW < DATA_WIDTH || OPW < RAM_ADDR_WIDTH || OPW < ROM_ADDR_WIDTH || WAIT_LIMIT < 1)
        $error("micro_core: OPW too narrow or WAIT_LIMIT < 1");

    typedef enum logic [2:0] {FETCH, DECODE, READ, WRITE, EXEC, HALT, ERROR} state_t;
    state_t state, next;

    logic [1:0] sync;
    logic rst;
    logic [OPW+3:0] ir;
    logic [3:0] op;
    logic [OPW-1:0] operand;
    logic [ROM_ADDR_WIDTH-1:0] pc;
    logic [DW-1:0] ar, mbr, imm, b, res;
    logic [DW:0] sum, dif;
    logic [3:0] f;
    logic upd, cn, vn, take, waiting, expired;

    always_ff @(posedge clk or posedge arst)
        if (arst) sync <= 2'b11;
        else sync <= {sync[0], 1'b0};

    assign rst = arst | sync[1];
    assign op = ir[OPW+3:OPW];
    assign operand = ir[OPW-1:0];
    assign imm = operand[DW-1:0];
    assign waiting = (bus.rom_req & ~bus.rom_ack) | (bus.ram_req & ~bus.ram_ack);

`ifdef MICRO_WDT_EN
    localparam int CW = $clog2(WAIT_LIMIT + 2);
    logic [CW-1:0] cnt;

    // Leaving a wait state always passes a non-waiting cycle, so this also clears on entry.
    always_ff @(posedge clk or posedge arst)
        if (arst) cnt <= '0;
        else cnt <= waiting ? cnt + 1'b1 : '0;

    assign expired = cnt >= CW'(WAIT_LIMIT);
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        next = state;
        case (state)
            FETCH:  next = bus.rom_ack ? DECODE : expired ? ERROR : FETCH;
            DECODE: next = op == 4'h3 ? WRITE :
                           (op == 4'h2 || (op >= 4'h4 && op <= 4'h8)) ? READ :
                           op == 4'hD ? HALT : op >= 4'hE ? ERROR : EXEC;
            READ:   next = bus.ram_ack ? EXEC : expired ? ERROR : READ;
            WRITE:  next = bus.ram_ack ? FETCH : expired ? ERROR : WRITE;
            EXEC:   next = FETCH;
            default: next = state;
        endcase
    end

    assign b = op == 4'h9 ? imm : mbr;
    assign sum = {1'b0, ar} + {1'b0, b};
    assign dif = {1'b0, ar} - {1'b0, b};
    assign take = op == 4'hA || (op == 4'hB && f[0]) || (op == 4'hC && f[1]);

    // f = {V,N,C,Z}; cn/vn default to held values so LD/LDI keep C and V
    always_comb begin
        res = ar;
        cn = f[1];
        vn = f[3];
        upd = 1'b1;
        case (op)
            4'h1: res = imm;
            4'h2: res = mbr;
            4'h4, 4'h9: begin
                res = sum[DW-1:0];
                cn = sum[DW];
                vn = ar[DW-1] == b[DW-1] && sum[DW-1] != ar[DW-1];
            end
            4'h5: begin
                res = dif[DW-1:0];
                cn = dif[DW];
                vn = ar[DW-1] != b[DW-1] && dif[DW-1] != ar[DW-1];
            end
            4'h6: begin res = ar & b; vn = 1'b0; end
            4'h7: begin res = ar | b; vn = 1'b0; end
            4'h8: begin res = ar ^ b; vn = 1'b0; end
            default: upd = 1'b0;
        endcase
    end

    // sync[1] only rises via arst, so holding state while it is set keeps everything at reset values.
    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            state <= FETCH;
            pc <= '0;
            ir <= '0;
            mbr <= '0;
            ar <= '0;
            f <= '0;
        end else if (!sync[1]) begin
            state <= next;
            if (state == FETCH && bus.rom_ack) begin
                ir <= bus.rom_data;
                pc <= pc + 1'b1;
            end
            if (state == READ && bus.ram_ack) mbr <= bus.ram_rdata;
            if (state == EXEC && upd) begin
                ar <= res;
                f <= {vn, res[DW-1], cn, res == '0};
            end
            if (state == EXEC && take) pc <= operand[ROM_ADDR_WIDTH-1:0];
        end

    assign bus.rom_req = ~rst & (state == FETCH);
    assign bus.rom_addr = pc;
    assign bus.ram_req = ~rst & (state == READ || state == WRITE);
    assign bus.ram_we = state == WRITE;
    assign bus.ram_addr = operand[RAM_ADDR_WIDTH-1:0];
    assign bus.ram_wdata = ar;
    assign acc = ar;
    assign flags = f;
    assign halted = state == HALT;
    assign error = state == ERROR;
endmodule
